// File: rtl/lcd_cmd_seq.sv
// Queues host commands and issues them one at a time to LCD_CTRL: earliest issue is one edge after the push.
// host_ready drops when the FIFO is full, after a Write is accepted, or once the sequence is done.
module lcd_cmd_seq #(
  parameter int DEPTH  = 8,
  parameter int ACK_TO = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt,
  output logic                     timeout_err,
  output logic                     seq_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TO + 1);
  localparam logic [AW:0]   FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TO - 1);

  typedef enum logic [2:0] {IDLE, WAIT_ACK, WAIT_BUSY, FINISH, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_seen;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    head, cmd_nxt;
  logic          cmd_valid_nxt, timeout_set;
  logic          accept, illegal, push, pop, full, empty;

  assign full       = (fifo_level == FULL_LVL);
  assign empty      = (fifo_level == '0);
  assign host_ready = !full && !wr_seen && (state != DONE);
  assign accept     = host_valid && host_ready;
  assign illegal    = (host_cmd[3:2] == 2'b11);
  assign push       = accept && !illegal;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wr_seen    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_level <= fifo_level + (AW+1)'(1);
      else if (!push && pop) fifo_level <= fifo_level - (AW+1)'(1);
      if (push && host_cmd == 4'd0) wr_seen <= 1'b1;
      if (accept && illegal && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      cmd_valid <= cmd_valid_nxt;
      timer     <= timer_nxt;
      if (timeout_set)       timeout_err <= 1'b1;
      if (state_nxt == DONE) seq_done    <= 1'b1;
    end
  end

  // done pre-empts everything, including an issue that would otherwise happen this edge
  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    cmd_valid_nxt = 1'b0;
    timer_nxt     = timer;
    timeout_set   = 1'b0;
    pop           = 1'b0;
    if (done) begin
      state_nxt = DONE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && !busy) begin
            pop           = 1'b1;
            cmd_nxt       = head;
            cmd_valid_nxt = 1'b1;
            timer_nxt     = '0;
            state_nxt     = (head == 4'd0) ? FINISH : WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (busy) begin
            state_nxt = WAIT_BUSY;
          end else if (timer == TIMER_LAST) begin
            timeout_set = 1'b1;
            state_nxt   = IDLE;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        WAIT_BUSY: begin
          if (!busy) state_nxt = IDLE;
        end
        FINISH:  state_nxt = FINISH;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: edge-indexed behavioural model plus directed scenarios with literal expectations.
module tb_lcd_cmd_seq;
  localparam int DEPTH  = 8;
  localparam int ACK_TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy = 1'b1;
  logic       done = 1'b0;
  logic [3:0] fifo_level;
  logic [7:0] drop_cnt;
  logic       timeout_err;
  logic       seq_done;

  lcd_cmd_seq #(.DEPTH(DEPTH), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // LCD_CTRL stand-in: 0 = busy low, 1 = busy held high, 2 = busy 5 cycles per command, done 3 after Write
  int lcd_mode = 1;
  int bcnt = 0;
  int dcnt = 0;
  always begin
    @(posedge clk);
    #1;
    done = 1'b0;
    if (lcd_mode == 1) begin
      busy = 1'b1;
    end else if (lcd_mode == 0) begin
      busy = 1'b0; bcnt = 0; dcnt = 0;
    end else begin
      if (bcnt > 0) bcnt--;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) done = 1'b1;
      end
      if (cmd_valid === 1'b1) begin
        if (cmd == 4'd0) dcnt = 3;
        else bcnt = 5;
      end
      busy = (bcnt > 0);
    end
  end

  // Model: a queue of stored codes, and the rule that a new issue needs the previous one
  // acknowledged (busy seen high then low) or abandoned ACK_TO edges after it was issued.
  int m_q[$];
  int m_ec = 0;
  int m_last = 0, m_ack = -1, m_rel = -1;
  int m_cmd = 0, m_drop = 0;
  bit m_have = 0, m_fin = 0, m_done = 0, m_wr = 0, m_tmo = 0, m_issued = 0;
  bit m_rdy, m_free;

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_q.delete();
      m_have = 0; m_fin = 0; m_done = 0; m_wr = 0; m_tmo = 0; m_issued = 0;
      m_cmd = 0; m_drop = 0; m_ack = -1; m_rel = -1; m_last = 0;
    end else begin
      m_ec++;
      m_rdy    = (m_q.size() < DEPTH) && !m_wr && !m_done;
      m_issued = 0;
      if (!m_done) begin
        if (done === 1'b1) begin
          m_done = 1;
        end else if (!m_fin) begin
          if (m_have && m_ack < 0 && busy && m_ec > m_last && m_ec - m_last <= ACK_TO)
            m_ack = m_ec;
          else if (m_have && m_ack >= 0 && m_ack < m_ec && m_rel < 0 && !busy)
            m_rel = m_ec;
          if (m_have && m_ack < 0 && !busy && m_ec - m_last == ACK_TO) m_tmo = 1;
          m_free = !m_have || (m_rel >= 0 && m_rel < m_ec) ||
                   (m_ack < 0 && m_ec - m_last > ACK_TO);
          if (m_free && m_q.size() > 0 && !busy) begin
            m_cmd = m_q.pop_front();
            m_issued = 1; m_have = 1; m_last = m_ec; m_ack = -1; m_rel = -1;
            if (m_cmd == 0) m_fin = 1;
          end
        end
      end
      if (host_valid && m_rdy) begin
        if (host_cmd >= 4'd12) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back(int'(host_cmd));
          if (host_cmd == 4'd0) m_wr = 1;
        end
      end
    end
  end

  int log_q[$];
  int max_level = 0;

  always begin
    @(negedge clk);
    check("cmd_valid", 32'(cmd_valid), 32'(m_issued));
    check("cmd", 32'(cmd), 32'(m_cmd));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("host_ready", 32'(host_ready), 32'((m_q.size() < DEPTH) && !m_wr && !m_done));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("timeout_err", 32'(timeout_err), 32'(m_tmo));
    check("seq_done", 32'(seq_done), 32'(m_done));
    if (cmd_valid === 1'b1) log_q.push_back(int'(cmd));
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves host_valid high so consecutive calls are back-to-back; caller drops it.
  task automatic push1(input int code, output int waited);
    logic r;
    waited = 0;
    r = 1'b0;
    host_cmd = 4'(code);
    host_valid = 1'b1;
    while (!r && waited < 300) begin
      @(negedge clk);
      r = host_ready;
      @(posedge clk);
      #1;
      if (!r) waited++;
    end
    if (!r) begin
      check("push_accept", 32'(r), 32'd1);
      host_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  int seq1[4] = '{1, 3, 9, 0};

  initial begin
    int w, stalls, n, mark;
    lcd_mode = 1;
    reset = 1'b0;
    cycles(3);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    reset = 1'b1;

    // image load in progress: everything queues
    stalls = 0;
    foreach (seq1[i]) begin
      push1(seq1[i], w);
      stalls += w;
    end
    host_valid = 1'b0;
    check("t1_stalls", 32'(stalls), 32'd0);
    check("t1_level", 32'(fifo_level), 32'd4);
    cycles(58);
    check("t1_no_issue", 32'(log_q.size()), 32'd0);
    lcd_mode = 2;
    n = 0;
    while (seq_done !== 1'b1 && n < 300) begin cycles(1); n++; end
    check("t2_seq_done", 32'(seq_done), 32'd1);
    check("t2_issues", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t2_order", 32'(log_q[i]), 32'(seq1[i]));
    check("t2_host_ready", 32'(host_ready), 32'd0);
    cycles(5);

    // fill to capacity, then resume as entries drain
    reset_dut();
    lcd_mode = 1;
    log_q.delete();
    max_level = 0;
    cycles(3);
    for (int i = 0; i < DEPTH; i++) push1(5, w);
    host_valid = 1'b0;
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ready_full", 32'(host_ready), 32'd0);
    lcd_mode = 2;
    push1(5, w);
    push1(5, w);
    host_valid = 1'b0;
    n = 0;
    while (log_q.size() < DEPTH + 2 && n < 300) begin cycles(1); n++; end
    check("t3_issues", 32'(log_q.size()), 32'd10);
    check("t3_max_level", 32'(max_level), 32'd8);
    cycles(10);

    // illegal codes are counted, not stored
    mark = log_q.size();
    push1(12, w);
    push1(15, w);
    push1(2, w);
    host_valid = 1'b0;
    check("t4_drop2", 32'(drop_cnt), 32'd2);
    cycles(15);
    check("t4_one_issue", 32'(log_q.size()), 32'(mark + 1));
    if (log_q.size() > mark) check("t4_code", 32'(log_q[mark]), 32'd2);
    for (int i = 0; i < 300; i++) push1(12 + (i % 4), w);
    host_valid = 1'b0;
    check("t4_drop_sat", 32'(drop_cnt), 32'd255);

    // no acknowledgement from LCD_CTRL
    lcd_mode = 0;
    cycles(2);
    mark = log_q.size();
    push1(4, w);
    push1(7, w);
    host_valid = 1'b0;
    cycles(10);
    check("t5_no_timeout_yet", 32'(timeout_err), 32'd0);
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin cycles(1); n++; end
    check("t5_timeout", 32'(timeout_err), 32'd1);
    n = 0;
    while (log_q.size() < mark + 2 && n < 40) begin cycles(1); n++; end
    check("t5_issues", 32'(log_q.size()), 32'(mark + 2));
    if (log_q.size() >= mark + 2) begin
      check("t5_first", 32'(log_q[mark]), 32'd4);
      check("t5_second", 32'(log_q[mark + 1]), 32'd7);
    end
    cycles(25);

    // reset in WAIT_BUSY with three entries queued
    reset_dut();
    lcd_mode = 2;
    cycles(2);
    push1(6, w);
    push1(1, w);
    push1(2, w);
    push1(3, w);
    host_valid = 1'b0;
    check("t6_level_before", 32'(fifo_level), 32'd3);
    check("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    lcd_mode = 0;
    #1;
    check("t6_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("t6_rst_cmd", 32'(cmd), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_ready", 32'(host_ready), 32'd1);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    check("t6_rst_timeout", 32'(timeout_err), 32'd0);
    check("t6_rst_seq_done", 32'(seq_done), 32'd0);
    cycles(2);
    reset = 1'b1;
    mark = log_q.size();
    cycles(10);
    check("t6_no_stale_issue", 32'(log_q.size()), 32'(mark));
    check("t6_level_after", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
